// File: rtl/unsi_div_16b_seq_pkg.sv
// Shared types and constants for the unsigned sequential divider family.
// Also provides the leading-one index used when early termination is compiled in.
package unsi_arith_pkg;

    localparam int DW_DEF = 8;
    localparam int QW     = 2 * DW_DEF;
    localparam int CNTW   = $clog2(QW);
    localparam logic [QW-1:0] DZ_QUOT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // A zero input reports index 0, so a zero dividend still runs exactly one iteration.
    function automatic int lead_one_idx(input logic [31:0] v);
        int idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/unsi_div_16b_seq_if.sv
// Operand/result handshake bundle for unsi_div_16b_seq.
// Both directions use valid/ready; results are qualified by out_valid.
interface unsi_div_16b_seq_if #(
    parameter int DW = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [2*DW-1:0]   dividend;
    logic [DW-1:0]     divisor;
    logic              out_valid;
    logic              out_ready;
    logic [2*DW-1:0]   quot;
    logic [DW-1:0]     rem;
    logic              dz;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quot, rem, dz
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quot, rem, dz
    );
endinterface

// File: rtl/unsi_div_16b_seq_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract, restore on borrow.
// Purely combinational.
module unsi_div_step #(
    parameter int DW = 8
) (
    input  logic [DW:0]   prem,
    input  logic          dbit,
    input  logic [DW-1:0] divisor,
    output logic [DW:0]   prem_next,
    output logic          qbit
);
    logic [DW:0] shifted;
    logic [DW:0] dvs_ext;

    assign shifted = {prem[DW-1:0], dbit};
    assign dvs_ext = {1'b0, divisor};

    // A set top bit means the shifted value already exceeds any DW-bit divisor;
    // the wrapped subtraction is then still exact because the result is < divisor.
    assign qbit      = prem[DW] | (shifted >= dvs_ext);
    assign prem_next = qbit ? (shifted - dvs_ext) : shifted;
endmodule

// File: rtl/unsi_div_16b_seq.sv
// Sequential unsigned restoring divider (2*DW / DW); UNSI_DIV_EARLY_TERM_EN skips leading dividend zeros.
// Latency accept + 2*DW iterations (divide-by-zero: 1); no operand accepted until the result is consumed.
module unsi_div_16b_seq
    import unsi_arith_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    unsi_div_16b_seq_if.slave bus
);
    localparam int QBITS = 2 * DW;
    localparam int CBITS = $clog2(QBITS);

    div_state_e         state;
    div_state_e         state_nxt;
    logic               accept;
    logic               in_rdy;
    logic               out_vld;

    logic [CBITS-1:0]   cnt;
    logic [CBITS-1:0]   cnt_start;
    logic [DW:0]        prem;
    logic [DW:0]        prem_nxt;
    logic               qbit;
    logic [QBITS-1:0]   dvd;
    logic [DW-1:0]      dvs;
    logic [QBITS-1:0]   quot;
    logic [DW-1:0]      rem;
    logic               dz;

`ifdef UNSI_DIV_EARLY_TERM_EN
    assign cnt_start = CBITS'(lead_one_idx(32'(bus.dividend)));
`else
    assign cnt_start = CBITS'(QBITS - 1);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        in_rdy    = 1'b0;
        out_vld   = 1'b0;
        case (state)
            IDLE: begin
                in_rdy = 1'b1;
                if (bus.in_valid) begin
                    accept    = 1'b1;
                    state_nxt = (bus.divisor == '0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (cnt == '0) state_nxt = DONE;
            end
            DONE: begin
                out_vld = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    unsi_div_step #(.DW(DW)) u_step (
        .prem      (prem),
        .dbit      (dvd[cnt]),
        .divisor   (dvs),
        .prem_next (prem_nxt),
        .qbit      (qbit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt  <= '0;
            prem <= '0;
            dvd  <= '0;
            dvs  <= '0;
            quot <= '0;
            rem  <= '0;
            dz   <= 1'b0;
        end else if (accept) begin
            dvd  <= bus.dividend;
            dvs  <= bus.divisor;
            prem <= '0;
            if (bus.divisor == '0) begin
                cnt  <= '0;
                quot <= {QBITS{1'b1}};
                rem  <= bus.dividend[DW-1:0];
                dz   <= 1'b1;
            end else begin
                cnt  <= cnt_start;
                quot <= '0;
                rem  <= '0;
                dz   <= 1'b0;
            end
        end else if (state == BUSY) begin
            prem <= prem_nxt;
            quot <= {quot[QBITS-2:0], qbit};
            if (cnt == '0) rem <= prem_nxt[DW-1:0];
            else           cnt <= cnt - CBITS'(1);
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_vld;
    assign bus.quot      = quot;
    assign bus.rem       = rem;
    assign bus.dz        = dz;
endmodule

// File: tb/tb_unsi_div_16b_seq.sv
// Directed checks of unsi_div_16b_seq: latency, arithmetic, divide-by-zero, backpressure, reset abort.
module tb_unsi_div_16b_seq;
    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    unsi_div_16b_seq_if #(.DW(8)) bus ();

    unsi_div_16b_seq #(.DW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Latency counts the accept edge as 1; capped so a stuck DUT cannot hang the run.
    task automatic send(input logic [15:0] a, input logic [7:0] b, output int lat);
        int guard;
        guard = 0;
        while (!bus.in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        bus.dividend = a;
        bus.divisor  = b;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.dividend = 16'($urandom);
        bus.divisor  = 8'($urandom);
        lat = 1;
        while (!bus.out_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    logic [15:0] va  [3] = '{16'd65535, 16'd1000, 16'd255};
    logic [7:0]  vb  [3] = '{8'd255,    8'd7,     8'd1};
    logic [15:0] vq  [3] = '{16'd257,   16'd142,  16'd255};
    logic [7:0]  vr  [3] = '{8'd0,      8'd6,     8'd0};
    int          vlf [3] = '{17, 17, 17};
    int          vle [3] = '{17, 11, 9};

    initial begin
        int          lat;
        logic [15:0] ra;
        logic [7:0]  rb;
        logic [15:0] eq;
        logic [7:0]  er;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  32'(bus.in_ready),  1);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_quot",      32'(bus.quot),      0);
        check("rst_rem",       32'(bus.rem),       0);
        check("rst_dz",        32'(bus.dz),        0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        bus.out_ready = 1'b1;
        send(16'd50000, 8'd200, lat);
        check("50000/200_lat",  32'(lat), 17);
        check("50000/200_quot", 32'(bus.quot), 250);
        check("50000/200_rem",  32'(bus.rem), 0);
        check("50000/200_dz",   32'(bus.dz), 0);

        for (int i = 0; i < 3; i++) begin
            send(va[i], vb[i], lat);
`ifdef UNSI_DIV_EARLY_TERM_EN
            check("vec_lat", 32'(lat), 32'(vle[i]));
`else
            check("vec_lat", 32'(lat), 32'(vlf[i]));
`endif
            check("vec_quot", 32'(bus.quot), 32'(vq[i]));
            check("vec_rem",  32'(bus.rem),  32'(vr[i]));
            check("vec_dz",   32'(bus.dz),   0);
        end

        send(16'd1234, 8'd0, lat);
        check("dz_lat",  32'(lat), 1);
        check("dz_quot", 32'(bus.quot), 32'hFFFF);
        check("dz_rem",  32'(bus.rem), 32'hD2);
        check("dz_flag", 32'(bus.dz), 1);

        // Result must hold while the consumer stalls.
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        send(16'd1000, 8'd7, lat);
        check("bp_vld_rise", 32'(bus.out_valid), 1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("bp_vld",  32'(bus.out_valid), 1);
            check("bp_quot", 32'(bus.quot), 142);
            check("bp_rem",  32'(bus.rem), 6);
            check("bp_rdy",  32'(bus.in_ready), 0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_post_vld", 32'(bus.out_valid), 0);
        check("bp_post_rdy", 32'(bus.in_ready), 1);

        bus.dividend = 16'd40000;
        bus.divisor  = 8'd3;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("abort_busy_rdy", 32'(bus.in_ready), 0);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_vld",  32'(bus.out_valid), 0);
        check("abort_rdy",  32'(bus.in_ready), 1);
        check("abort_quot", 32'(bus.quot), 0);
        rst_n = 1'b1;
        send(16'd9, 8'd2, lat);
`ifdef UNSI_DIV_EARLY_TERM_EN
        check("9/2_lat", 32'(lat), 5);
`else
        check("9/2_lat", 32'(lat), 17);
`endif
        check("9/2_quot", 32'(bus.quot), 4);
        check("9/2_rem",  32'(bus.rem), 1);

`ifdef UNSI_DIV_EARLY_TERM_EN
        send(16'd5, 8'd2, lat);
        check("et_5/2_lat",  32'(lat), 4);
        check("et_5/2_quot", 32'(bus.quot), 2);
        check("et_5/2_rem",  32'(bus.rem), 1);
        send(16'd0, 8'd9, lat);
        check("et_0/9_lat",  32'(lat), 2);
        check("et_0/9_quot", 32'(bus.quot), 0);
        check("et_0/9_rem",  32'(bus.rem), 0);
`endif

        for (int n = 0; n < 200; n++) begin
            ra = 16'($urandom);
            rb = 8'($urandom_range(1, 255));
            eq = ra / 16'(rb);
            er = 8'(ra % 16'(rb));
            send(ra, rb, lat);
            check("rand_vld",  32'(bus.out_valid), 1);
            check("rand_quot", 32'(bus.quot), 32'(eq));
            check("rand_rem",  32'(bus.rem),  32'(er));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
